alu_mc_unit: RTL and testbench
==============================

Name: alu_mc_unit

Overview:
- Parametrised-width ALU with integrated ALU-control decode (alu_op + funct).
- Adds multi-cycle iterative shifts and an optional iterative multiply behind a valid/ready handshake.
- Sits in the execute stage of the multi-cycle datapath.
- The control FSM stalls the issue side while in_ready is low.

Parameters:
- W, 32: operand and result width. Must be ≥4 and a power of 2.
- SW, $clog2(W): shift-amount width (derived; do not override).
- MUL_EN, 1: 1 enables the MULT funct; 0 makes MULT decode as illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- alu_op  input  2  00 = ADD, 01 = SUB, 10 = decode funct, 11 = SLT (immediate compare)
- funct  input  6  R-type function field, used only when alu_op = 10
- shamt  input  SW  shift amount for SLL/SRL/SRA
- a  input  W  operand A (rs)
- b  input  W  operand B (rt or imm); b is the shifted value for shift ops
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  W  operation result
- zero  output  1  result == 0
- illegal  output  1  unsupported alu_op/funct combination; valid with out_valid

Behaviour:
- Funct decode (alu_op = 10):
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT
  - 000000 SLL, 000010 SRL, 000011 SRA
  - 011000 MULT (low W bits of a*b; only when MUL_EN = 1)
  - Any other funct: illegal = 1, result = 0.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^W; no overflow flag.
  - SLT is a signed compare. result = {W-1 zeros, (a-b) sign XOR signed overflow}.
- FSM states: IDLE, SHIFT, MUL, DONE.
- Reset: state = IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 1, illegal = 0, internal counters = 0.
- IDLE:
  - in_ready = 1. Accept when in_valid is high at a clock edge; operands and decoded op are latched.
  - Single-cycle ops (ADD/SUB/AND/OR/NOR/SLT/illegal): compute and go to DONE. out_valid rises 1 cycle after accept.
  - Shift with shamt = 0: result = b, go to DONE.
  - Shift with shamt = k > 0: load b, counter = k, go to SHIFT.
  - MULT: acc = 0, multiplier = b, multiplicand = a, counter = W, go to MUL.
- SHIFT:
  - Each cycle, shift the register 1 bit: SLL fills 0 at the LSB, SRL fills 0 at the MSB, SRA replicates the MSB.
  - Decrement counter; when it reaches 0, go to DONE. out_valid rises k+1 cycles after accept.
- MUL:
  - Each cycle: if multiplier LSB = 1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter--.
  - After W cycles go to DONE. out_valid rises W+1 cycles after accept.
- DONE:
  - out_valid = 1; result, zero and illegal are held stable.
  - When out_ready = 1, go to IDLE; out_valid drops next cycle.
  - in_ready = 0 in DONE. No bypass: back-to-back single-cycle ops issue every 2 cycles minimum.
- in_ready is 0 in SHIFT, MUL and DONE. in_valid is ignored in those states, and inputs may change freely there.
- Reset mid-operation (any state): the next edge returns to the reset values. Any pending result is discarded, and out_valid never pulses.
- out_ready high while not in DONE has no effect.
- zero is combinational from the registered result and is meaningful only while out_valid = 1.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 (alu_op=00) -> out_valid 1 cycle after accept, result=0x80000000, zero=0, illegal=0. SUB a=5 b=5 (alu_op=01) -> result=0, zero=1.
- alu_op=10, funct=101010 with a=0xFFFFFFFF (-1), b=1 -> result=1. a=0x80000000, b=0x7FFFFFFF -> result=1 (overflow-corrected). alu_op=11 with a=3, b=2 -> result=0.
- SRA b=0x80000000 shamt=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000; in_ready=0 throughout. SRL on the same inputs -> 0x08000000. SLL shamt=0 b=0x1234 -> result=0x1234 in 1 cycle.
- MULT a=0x00010003 b=0x00020005 (MUL_EN=1) -> result=0x000B000F after W+1=33 cycles. Same op with MUL_EN=0 -> illegal=1, result=0 in 1 cycle. funct=111111 -> illegal=1.
- Hold out_ready=0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready -> IDLE, in_ready=1 next cycle.
- Assert rst_n=0 for 1 cycle during the MUL state (cycle 10) -> next cycle IDLE, out_valid=0, result=0, zero=1. A new ADD 2+2 then completes with result=4.

Source files
------------

// File: rtl/alu_mc_unit.sv
// Execute-stage ALU with alu_op/funct decode, iterative shifts and
// optional iterative multiply behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  request handshake (accept in IDLE only)
//   alu_op, funct       00 ADD, 01 SUB, 10 decode funct, 11 SLT
//   shamt               shift amount for SLL/SRL/SRA
//   a, b                operands; b is the value shifted
//   out_valid, out_ready result handshake (held in DONE)
//   result, zero        registered result and result==0 flag
//   illegal             unsupported alu_op/funct, valid with out_valid
module alu_mc_unit #(
   parameter int W      = 32,
   parameter int SW     = $clog2(W),
   parameter bit MUL_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    alu_op,
   input  logic [5:0]    funct,
   input  logic [SW-1:0] shamt,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  result,
   output logic          zero,
   output logic          illegal
);

   localparam int CW = SW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_MUL,
      S_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_NOR,
      OP_SLT,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_MUL,
      OP_ILL
   } op_t;

   state_t         state_q, state_d;
   op_t            sop_q, sop_d;
   logic [W-1:0]   res_q, res_d;
   logic [W-1:0]   mc_q, mc_d;
   logic [W-1:0]   mp_q, mp_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ill_q, ill_d;

   op_t            op;
   logic [W-1:0]   sum;
   logic [W-1:0]   diff;
   logic           ovf;
   logic           lt;
   logic [W-1:0]   alu_res;

   always_comb begin
      op = OP_ILL;
      unique case (alu_op)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b11: op = OP_SLT;
         2'b10: begin
            case (funct)
               6'b100000: op = OP_ADD;
               6'b100010: op = OP_SUB;
               6'b100100: op = OP_AND;
               6'b100101: op = OP_OR;
               6'b100111: op = OP_NOR;
               6'b101010: op = OP_SLT;
               6'b000000: op = OP_SLL;
               6'b000010: op = OP_SRL;
               6'b000011: op = OP_SRA;
               6'b011000: op = MUL_EN ? OP_MUL : OP_ILL;
               default:   op = OP_ILL;
            endcase
         end
      endcase
   end

   // Signed less-than: sign of a-b corrected by signed overflow.
   assign sum  = a + b;
   assign diff = a - b;
   assign ovf  = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]);
   assign lt   = diff[W-1] ^ ovf;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = sum;
         OP_SUB:  alu_res = diff;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(W-1){1'b0}}, lt};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sop_d   = sop_q;
      res_d   = res_q;
      mc_d    = mc_q;
      mp_d    = mp_q;
      cnt_d   = cnt_q;
      ill_d   = ill_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               ill_d   = (op == OP_ILL);
               res_d   = alu_res;
               sop_d   = op;
               state_d = S_DONE;
               if (op == OP_SLL || op == OP_SRL || op == OP_SRA) begin
                  res_d = b;
                  if (shamt != '0) begin
                     cnt_d   = CW'(shamt);
                     state_d = S_SHIFT;
                  end
               end else if (op == OP_MUL) begin
                  res_d   = '0;
                  mc_d    = a;
                  mp_d    = b;
                  cnt_d   = CW'(W);
                  state_d = S_MUL;
               end
            end
         end
         S_SHIFT: begin
            case (sop_q)
               OP_SLL:  res_d = {res_q[W-2:0], 1'b0};
               OP_SRL:  res_d = {1'b0, res_q[W-1:1]};
               default: res_d = {res_q[W-1], res_q[W-1:1]};
            endcase
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_MUL: begin
            // res_q doubles as the accumulator.
            if (mp_q[0]) res_d = res_q + mc_q;
            mc_d  = {mc_q[W-2:0], 1'b0};
            mp_d  = {1'b0, mp_q[W-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sop_q   <= OP_ADD;
         res_q   <= '0;
         mc_q    <= '0;
         mp_q    <= '0;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sop_q   <= sop_d;
         res_q   <= res_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = res_q;
   assign zero      = (res_q == '0);
   assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed testbench for alu_mc_unit.
// Second instance built with MUL_EN=0 shares all inputs.
module tb_alu_mc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_ready;

   logic        in_ready, out_valid, zero, illegal;
   logic [31:0] result;
   logic        in_ready0, out_valid0, zero0, illegal0;
   logic [31:0] result0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_mc_unit #(.W(32), .MUL_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .shamt(shamt),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   alu_mc_unit #(.W(32), .MUL_EN(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready0),
      .alu_op(alu_op), .funct(funct), .shamt(shamt),
      .a(a), .b(b),
      .out_valid(out_valid0), .out_ready(out_ready),
      .result(result0), .zero(zero0), .illegal(illegal0)
   );

   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] va,
                        input logic [31:0] vb, output int lat,
                        output bit rdy_seen);
      @(negedge clk);
      alu_op = op; funct = fn; shamt = sh; a = va; b = vb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         rdy_seen |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      rdy_seen |= in_ready;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (result !== 32'h0) begin
         errors++; $display("FAIL reset_result got %h want 0", result);
      end
      checks++;
      if (zero !== 1'b1) begin
         errors++; $display("FAIL reset_zero got %b want 1", zero);
      end
      checks++;
      if (illegal !== 1'b0) begin
         errors++; $display("FAIL reset_illegal got %b want 0", illegal);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_addsub();
      int lat; bit rs;
      issue(2'b00, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1, lat, rs);
      checks++;
      if (lat !== 1) begin
         errors++; $display("FAIL add_latency got %0d want 1", lat);
      end
      checks++;
      if (result !== 32'h80000000) begin
         errors++; $display("FAIL add_result got %h want 80000000", result);
      end
      checks++;
      if (zero !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL add_flags got z=%b i=%b want 0 0", zero, illegal);
      end
      drain();
      issue(2'b01, 6'h0, 5'd0, 32'd5, 32'd5, lat, rs);
      checks++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL sub_zero got %h z=%b want 0 z=1", result, zero);
      end
      drain();
   endtask

   task automatic test_slt();
      int lat; bit rs;
      issue(2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, lat, rs);
      checks++;
      if (result !== 32'h1) begin
         errors++; $display("FAIL slt_neg got %h want 1", result);
      end
      drain();
      issue(2'b10, 6'b101010, 5'd0, 32'h80000000, 32'h7FFFFFFF, lat, rs);
      checks++;
      if (result !== 32'h1) begin
         errors++; $display("FAIL slt_ovf got %h want 1", result);
      end
      drain();
      issue(2'b11, 6'h0, 5'd0, 32'd3, 32'd2, lat, rs);
      checks++;
      if (result !== 32'h0) begin
         errors++; $display("FAIL slt_imm got %h want 0", result);
      end
      drain();
   endtask

   task automatic test_shift();
      int lat; bit rs;
      issue(2'b10, 6'b000011, 5'd4, 32'h0, 32'h80000000, lat, rs);
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL sra_latency got %0d want 5", lat);
      end
      checks++;
      if (result !== 32'hF8000000) begin
         errors++; $display("FAIL sra_result got %h want f8000000", result);
      end
      checks++;
      if (rs !== 1'b0) begin
         errors++; $display("FAIL sra_in_ready got %b want 0", rs);
      end
      drain();
      issue(2'b10, 6'b000010, 5'd4, 32'h0, 32'h80000000, lat, rs);
      checks++;
      if (result !== 32'h08000000) begin
         errors++; $display("FAIL srl_result got %h want 08000000", result);
      end
      drain();
      issue(2'b10, 6'b000000, 5'd0, 32'h0, 32'h1234, lat, rs);
      checks++;
      if (lat !== 1 || result !== 32'h1234) begin
         errors++;
         $display("FAIL sll0 got lat=%0d %h want 1 1234", lat, result);
      end
      drain();
      issue(2'b10, 6'b000000, 5'd3, 32'h0, 32'hA0000001, lat, rs);
      checks++;
      if (lat !== 4 || result !== 32'h00000008) begin
         errors++;
         $display("FAIL sll3 got lat=%0d %h want 4 00000008", lat, result);
      end
      drain();
   endtask

   task automatic test_mult();
      int lat;
      @(negedge clk);
      alu_op = 2'b10; funct = 6'b011000; shamt = '0;
      a = 32'h00010003; b = 32'h00020005;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      checks++;
      if (out_valid0 !== 1'b1 || illegal0 !== 1'b1 || result0 !== 32'h0) begin
         errors++;
         $display("FAIL mul_disabled got v=%b i=%b %h want 1 1 0",
                  out_valid0, illegal0, result0);
      end
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL mul_latency got %0d want 33", lat);
      end
      checks++;
      if (result !== 32'h000B000F || illegal !== 1'b0) begin
         errors++;
         $display("FAIL mul_result got %h i=%b want 000b000f 0",
                  result, illegal);
      end
      drain();
   endtask

   task automatic test_illegal();
      int lat; bit rs;
      issue(2'b10, 6'b111111, 5'd0, 32'h5, 32'h6, lat, rs);
      checks++;
      if (lat !== 1 || illegal !== 1'b1 || result !== 32'h0) begin
         errors++;
         $display("FAIL illegal_funct got lat=%0d i=%b %h want 1 1 0",
                  lat, illegal, result);
      end
      drain();
   endtask

   task automatic test_hold();
      int lat; bit rs;
      issue(2'b00, 6'h0, 5'd0, 32'd1, 32'd2, lat, rs);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d got v=%b %h r=%b want 1 3 0",
                     i, out_valid, result, in_ready);
         end
         in_valid = (i == 4);
         a = 32'd7; b = 32'd7;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release got v=%b r=%b want 0 1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit rs; bit seen;
      @(negedge clk);
      alu_op = 2'b10; funct = 6'b011000;
      a = 32'h00010003; b = 32'h00020005;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 ||
          in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset got v=%b %h z=%b r=%b want 0 0 1 1",
                  out_valid, result, zero, in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= out_valid;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midreset_pulse got %b want 0", seen);
      end
      issue(2'b00, 6'h0, 5'd0, 32'd2, 32'd2, lat, rs);
      checks++;
      if (lat !== 1 || result !== 32'd4) begin
         errors++;
         $display("FAIL post_reset_add got lat=%0d %h want 1 4", lat, result);
      end
      drain();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = '0; funct = '0; shamt = '0; a = '0; b = '0;
      test_reset();
      test_addsub();
      test_slt();
      test_shift();
      test_mult();
      test_illegal();
      test_hold();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
